// File: rtl/rf_port_arbiter_pkg.sv
// Shared constants and types for the register-file port arbiter.
package rf_arb_pkg;

  localparam int unsigned RF_DEPTH = 4;
  localparam int unsigned RF_WIDTH = 32;

  // Round-robin pointer and select encoding: bit 0 of a grant vector is side A.
  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_e;

endpackage

// File: rtl/rf_port_arbiter_if.sv
// Requester and register-file signal bundle for rf_port_arbiter.
interface rf_port_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned WIDTH = RF_WIDTH
);

  logic             rd_req_a,  rd_req_b;
  logic [DEPTH-1:0] rd_addr_a, rd_addr_b;
  logic             rd_gnt_a,  rd_gnt_b;
  logic             rd_vld_a,  rd_vld_b;
  logic [WIDTH-1:0] rd_data_a, rd_data_b;

  logic             wr_req_a,  wr_req_b;
  logic [DEPTH-1:0] wr_addr_a, wr_addr_b;
  logic [WIDTH-1:0] wr_data_a, wr_data_b;
  logic             wr_gnt_a,  wr_gnt_b;

  logic [DEPTH-1:0] rf_r_addr;
  logic [WIDTH-1:0] rf_r_data;
  logic             rf_wr_en;
  logic [DEPTH-1:0] rf_w_addr;
  logic [WIDTH-1:0] rf_w_data;

  modport master (
    output rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
    input  rd_gnt_a, rd_gnt_b, rd_vld_a, rd_vld_b, rd_data_a, rd_data_b,
    output wr_req_a, wr_req_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    input  wr_gnt_a, wr_gnt_b,
    input  rf_r_addr, rf_wr_en, rf_w_addr, rf_w_data,
    output rf_r_data
  );

  modport slave (
    input  rd_req_a, rd_req_b, rd_addr_a, rd_addr_b,
    output rd_gnt_a, rd_gnt_b, rd_vld_a, rd_vld_b, rd_data_a, rd_data_b,
    input  wr_req_a, wr_req_b, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b,
    output wr_gnt_a, wr_gnt_b,
    output rf_r_addr, rf_wr_en, rf_w_addr, rf_w_data,
    input  rf_r_data
  );

endinterface

// File: rtl/rf_port_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; masked requests neither win nor move the pointer.
module rr_arb2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       clr_n,
  input  logic [1:0] req,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  side_e      ptr_q, ptr_d;
  logic [1:0] cand;

  always_comb begin
    cand  = req & ~mask;
    gnt   = '0;
    ptr_d = ptr_q;
    unique case (cand)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        gnt   = (ptr_q == SIDE_A) ? 2'b01 : 2'b10;
        ptr_d = (ptr_q == SIDE_A) ? SIDE_B : SIDE_A;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) ptr_q <= SIDE_A;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin sharing of the register-file read and write ports between two requesters each.
// Define RF_BYPASS_EN to forward same-cycle write data to a colliding read instead of stalling it.
module rf_port_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = RF_DEPTH,
  parameter int unsigned WIDTH = RF_WIDTH
) (
  input logic               clk,
  input logic               clr_n,
  rf_port_arbiter_if.slave  bus
);

  logic [1:0]       wr_req, wr_gnt, rd_req, rd_gnt, rd_mask;
  logic             w_en;
  logic [DEPTH-1:0] w_addr, r_addr;
  logic [WIDTH-1:0] w_data, cap_data;

  logic             rd_vld_a_q, rd_vld_b_q;
  logic [WIDTH-1:0] rd_data_a_q, rd_data_b_q;

  // Requests are gated by reset so grants and the write strobe are quiet while clr_n is low.
  assign wr_req = {bus.wr_req_b, bus.wr_req_a} & {2{clr_n}};
  assign rd_req = {bus.rd_req_b, bus.rd_req_a} & {2{clr_n}};

  rr_arb2 u_wr_arb (
    .clk  (clk),
    .clr_n(clr_n),
    .req  (wr_req),
    .mask ('0),
    .gnt  (wr_gnt)
  );

  always_comb begin
    w_en   = |wr_gnt;
    w_addr = '0;
    w_data = '0;
    if (wr_gnt[0]) begin
      w_addr = bus.wr_addr_a;
      w_data = bus.wr_data_a;
    end else if (wr_gnt[1]) begin
      w_addr = bus.wr_addr_b;
      w_data = bus.wr_data_b;
    end
  end

`ifdef RF_BYPASS_EN
  assign rd_mask  = '0;
  assign cap_data = (w_en && (r_addr == w_addr)) ? w_data : bus.rf_r_data;
`else
  // A read colliding with this cycle's write waits one cycle for the committed value.
  assign rd_mask  = {w_en && (bus.rd_addr_b == w_addr),
                     w_en && (bus.rd_addr_a == w_addr)};
  assign cap_data = bus.rf_r_data;
`endif

  rr_arb2 u_rd_arb (
    .clk  (clk),
    .clr_n(clr_n),
    .req  (rd_req),
    .mask (rd_mask),
    .gnt  (rd_gnt)
  );

  always_comb begin
    r_addr = '0;
    if (rd_gnt[0])      r_addr = bus.rd_addr_a;
    else if (rd_gnt[1]) r_addr = bus.rd_addr_b;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rd_vld_a_q  <= 1'b0;
      rd_vld_b_q  <= 1'b0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
    end else begin
      rd_vld_a_q <= rd_gnt[0];
      rd_vld_b_q <= rd_gnt[1];
      if (rd_gnt[0]) rd_data_a_q <= cap_data;
      if (rd_gnt[1]) rd_data_b_q <= cap_data;
    end
  end

  assign bus.wr_gnt_a  = wr_gnt[0];
  assign bus.wr_gnt_b  = wr_gnt[1];
  assign bus.rf_wr_en  = w_en;
  assign bus.rf_w_addr = w_addr;
  assign bus.rf_w_data = w_data;
  assign bus.rd_gnt_a  = rd_gnt[0];
  assign bus.rd_gnt_b  = rd_gnt[1];
  assign bus.rf_r_addr = r_addr;
  assign bus.rd_vld_a  = rd_vld_a_q;
  assign bus.rd_vld_b  = rd_vld_b_q;
  assign bus.rd_data_a = rd_data_a_q;
  assign bus.rd_data_b = rd_data_b_q;

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed self-checking bench for rf_port_arbiter with a behavioural register file.
module tb_rf_port_arbiter;

  logic clk;
  logic clr_n;
  int   tests;
  int   fails;

  rf_port_arbiter_if #(.DEPTH(4), .WIDTH(32)) bus ();

  rf_port_arbiter #(.DEPTH(4), .WIDTH(32)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .bus  (bus.slave)
  );

  logic [31:0] rf_mem [0:15];
  logic        pre_en;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;

  assign bus.rf_r_data = rf_mem[bus.rf_r_addr];

  always @(posedge clk) begin
    if (pre_en)             rf_mem[pre_addr] <= pre_data;
    else if (bus.rf_wr_en)  rf_mem[bus.rf_w_addr] <= bus.rf_w_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rd_req_a = 1'b0; bus.rd_req_b = 1'b0;
    bus.rd_addr_a = '0;  bus.rd_addr_b = '0;
    bus.wr_req_a = 1'b0; bus.wr_req_b = 1'b0;
    bus.wr_addr_a = '0;  bus.wr_addr_b = '0;
    bus.wr_data_a = '0;  bus.wr_data_b = '0;
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    idle();
    preload(4'd3, 32'hDEADBEEF);
    preload(4'd9, 32'h0000_0099);
    preload(4'd2, 32'h2222_2222);
    preload(4'd7, 32'h0000_0077);
    @(negedge clk);
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd3;
    bus.wr_req_a = 1'b1; bus.wr_addr_a = 4'd4; bus.wr_data_a = 32'h1;
    #1;
    tests++; if (bus.rd_vld_a !== 1'b0 || bus.rd_vld_b !== 1'b0) begin fails++; $display("FAIL reset_vld: got a=%b b=%b want 0 0", bus.rd_vld_a, bus.rd_vld_b); end
    tests++; if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin fails++; $display("FAIL reset_data: got a=%h b=%h want 0 0", bus.rd_data_a, bus.rd_data_b); end
    tests++; if (bus.rd_gnt_a !== 1'b0 || bus.wr_gnt_a !== 1'b0) begin fails++; $display("FAIL reset_gnt: got rd=%b wr=%b want 0 0", bus.rd_gnt_a, bus.wr_gnt_a); end
    tests++; if (bus.rf_wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en: got %b want 0", bus.rf_wr_en); end
    @(negedge clk);
    idle();
    clr_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd3;
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b1 || bus.rd_gnt_b !== 1'b0) begin fails++; $display("FAIL single_gnt: got a=%b b=%b want 1 0", bus.rd_gnt_a, bus.rd_gnt_b); end
    tests++; if (bus.rf_r_addr !== 4'd3) begin fails++; $display("FAIL single_raddr: got %0d want 3", bus.rf_r_addr); end
    @(negedge clk);
    bus.rd_req_a = 1'b0;
    #1;
    tests++; if (bus.rd_vld_a !== 1'b1 || bus.rd_data_a !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got vld=%b data=%h want 1 deadbeef", bus.rd_vld_a, bus.rd_data_a); end
    @(negedge clk);
    #1;
    tests++; if (bus.rd_vld_a !== 1'b0 || bus.rd_data_a !== 32'hDEADBEEF) begin fails++; $display("FAIL single_hold: got vld=%b data=%h want 0 deadbeef", bus.rd_vld_a, bus.rd_data_a); end
  endtask

  task automatic test_dual_read();
    logic ea, eb, va, vb;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.rd_req_a = (i < 4); bus.rd_addr_a = 4'd3;
      bus.rd_req_b = (i < 4); bus.rd_addr_b = 4'd9;
      #1;
      ea = (i < 4) && (i % 2 == 0);
      eb = (i < 4) && (i % 2 == 1);
      va = (i > 0) && ((i - 1) % 2 == 0);
      vb = (i > 0) && ((i - 1) % 2 == 1);
      tests++; if (bus.rd_gnt_a !== ea || bus.rd_gnt_b !== eb) begin fails++; $display("FAIL dual_gnt[%0d]: got a=%b b=%b want %b %b", i, bus.rd_gnt_a, bus.rd_gnt_b, ea, eb); end
      tests++; if (bus.rd_vld_a !== va || bus.rd_vld_b !== vb) begin fails++; $display("FAIL dual_vld[%0d]: got a=%b b=%b want %b %b", i, bus.rd_vld_a, bus.rd_vld_b, va, vb); end
      if (va) begin tests++; if (bus.rd_data_a !== 32'hDEADBEEF) begin fails++; $display("FAIL dual_data_a[%0d]: got %h want deadbeef", i, bus.rd_data_a); end end
      if (vb) begin tests++; if (bus.rd_data_b !== 32'h99) begin fails++; $display("FAIL dual_data_b[%0d]: got %h want 99", i, bus.rd_data_b); end end
    end
  endtask

  task automatic test_dual_write();
    @(negedge clk);
    bus.wr_req_a = 1'b1; bus.wr_addr_a = 4'd5; bus.wr_data_a = 32'h11;
    bus.wr_req_b = 1'b1; bus.wr_addr_b = 4'd6; bus.wr_data_b = 32'h22;
    #1;
    tests++; if (bus.wr_gnt_a !== 1'b1 || bus.wr_gnt_b !== 1'b0 || bus.rf_wr_en !== 1'b1) begin fails++; $display("FAIL wr_first: got a=%b b=%b en=%b want 1 0 1", bus.wr_gnt_a, bus.wr_gnt_b, bus.rf_wr_en); end
    tests++; if (bus.rf_w_addr !== 4'd5 || bus.rf_w_data !== 32'h11) begin fails++; $display("FAIL wr_first_bus: got %0d/%h want 5/11", bus.rf_w_addr, bus.rf_w_data); end
    @(negedge clk);
    bus.wr_req_a = 1'b0;
    #1;
    tests++; if (bus.wr_gnt_a !== 1'b0 || bus.wr_gnt_b !== 1'b1) begin fails++; $display("FAIL wr_second: got a=%b b=%b want 0 1", bus.wr_gnt_a, bus.wr_gnt_b); end
    tests++; if (bus.rf_w_addr !== 4'd6 || bus.rf_w_data !== 32'h22) begin fails++; $display("FAIL wr_second_bus: got %0d/%h want 6/22", bus.rf_w_addr, bus.rf_w_data); end
    tests++; if (rf_mem[5] !== 32'h11) begin fails++; $display("FAIL wr_reg5: got %h want 11", rf_mem[5]); end
    @(negedge clk);
    bus.wr_req_a = 1'b1; bus.wr_addr_a = 4'd10; bus.wr_data_a = 32'hA0;
    bus.wr_req_b = 1'b1; bus.wr_addr_b = 4'd11; bus.wr_data_b = 32'hB0;
    #1;
    tests++; if (bus.wr_gnt_a !== 1'b0 || bus.wr_gnt_b !== 1'b1 || bus.rf_w_addr !== 4'd11) begin fails++; $display("FAIL wr_ptr_b: got a=%b b=%b addr=%0d want 0 1 11", bus.wr_gnt_a, bus.wr_gnt_b, bus.rf_w_addr); end
    tests++; if (rf_mem[6] !== 32'h22) begin fails++; $display("FAIL wr_reg6: got %h want 22", rf_mem[6]); end
    @(negedge clk);
    bus.wr_req_b = 1'b0;
    #1;
    tests++; if (bus.wr_gnt_a !== 1'b1 || bus.rf_w_addr !== 4'd10) begin fails++; $display("FAIL wr_after_b: got a=%b addr=%0d want 1 10", bus.wr_gnt_a, bus.rf_w_addr); end
    @(negedge clk);
    idle();
    #1;
    tests++; if (bus.rf_wr_en !== 1'b0 || bus.rf_w_addr !== 4'd0 || bus.rf_w_data !== 32'h0) begin fails++; $display("FAIL wr_idle: got en=%b addr=%0d data=%h want 0 0 0", bus.rf_wr_en, bus.rf_w_addr, bus.rf_w_data); end
    tests++; if (rf_mem[10] !== 32'hA0 || rf_mem[11] !== 32'hB0) begin fails++; $display("FAIL wr_reg10_11: got %h/%h want a0/b0", rf_mem[10], rf_mem[11]); end
  endtask

  task automatic test_raw();
    @(negedge clk);
    bus.wr_req_a = 1'b1; bus.wr_addr_a = 4'd7; bus.wr_data_a = 32'h55;
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd7;
    #1;
    tests++; if (bus.wr_gnt_a !== 1'b1) begin fails++; $display("FAIL raw_wr_gnt: got %b want 1", bus.wr_gnt_a); end
`ifndef RF_BYPASS_EN
    tests++; if (bus.rd_gnt_a !== 1'b0) begin fails++; $display("FAIL raw_stall: got %b want 0", bus.rd_gnt_a); end
    @(negedge clk);
    bus.wr_req_a = 1'b0;
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b1 || bus.rf_r_addr !== 4'd7) begin fails++; $display("FAIL raw_retry: got gnt=%b addr=%0d want 1 7", bus.rd_gnt_a, bus.rf_r_addr); end
    @(negedge clk);
    bus.rd_req_a = 1'b0;
    #1;
`else
    tests++; if (bus.rd_gnt_a !== 1'b1) begin fails++; $display("FAIL raw_bypass_gnt: got %b want 1", bus.rd_gnt_a); end
    @(negedge clk);
    idle();
    #1;
`endif
    tests++; if (bus.rd_vld_a !== 1'b1 || bus.rd_data_a !== 32'h55) begin fails++; $display("FAIL raw_data: got vld=%b data=%h want 1 55", bus.rd_vld_a, bus.rd_data_a); end
  endtask

  task automatic test_raw_split();
    @(negedge clk);
    bus.wr_req_a = 1'b1; bus.wr_addr_a = 4'd2; bus.wr_data_a = 32'h2A2A2A2A;
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd2;
    bus.rd_req_b = 1'b1; bus.rd_addr_b = 4'd9;
    #1;
`ifndef RF_BYPASS_EN
    tests++; if (bus.rd_gnt_a !== 1'b0 || bus.rd_gnt_b !== 1'b1 || bus.rf_r_addr !== 4'd9) begin fails++; $display("FAIL split_c0: got a=%b b=%b addr=%0d want 0 1 9", bus.rd_gnt_a, bus.rd_gnt_b, bus.rf_r_addr); end
    @(negedge clk);
    bus.wr_req_a = 1'b0; bus.rd_req_b = 1'b0;
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b1 || bus.rf_r_addr !== 4'd2) begin fails++; $display("FAIL split_c1: got a=%b addr=%0d want 1 2", bus.rd_gnt_a, bus.rf_r_addr); end
    tests++; if (bus.rd_vld_b !== 1'b1 || bus.rd_data_b !== 32'h99) begin fails++; $display("FAIL split_b_data: got vld=%b data=%h want 1 99", bus.rd_vld_b, bus.rd_data_b); end
    @(negedge clk);
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd3;
    bus.rd_req_b = 1'b1; bus.rd_addr_b = 4'd9;
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b1 || bus.rd_gnt_b !== 1'b0) begin fails++; $display("FAIL split_ptr_held: got a=%b b=%b want 1 0", bus.rd_gnt_a, bus.rd_gnt_b); end
    tests++; if (bus.rd_vld_a !== 1'b1 || bus.rd_data_a !== 32'h2A2A2A2A) begin fails++; $display("FAIL split_a_data: got vld=%b data=%h want 1 2a2a2a2a", bus.rd_vld_a, bus.rd_data_a); end
    @(negedge clk);
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b0 || bus.rd_gnt_b !== 1'b1) begin fails++; $display("FAIL split_ptr_flip: got a=%b b=%b want 0 1", bus.rd_gnt_a, bus.rd_gnt_b); end
    tests++; if (bus.rd_vld_a !== 1'b1 || bus.rd_data_a !== 32'hDEADBEEF) begin fails++; $display("FAIL split_a3_data: got vld=%b data=%h want 1 deadbeef", bus.rd_vld_a, bus.rd_data_a); end
`else
    tests++; if (bus.rd_gnt_a !== 1'b1 || bus.rd_gnt_b !== 1'b0 || bus.rf_r_addr !== 4'd2) begin fails++; $display("FAIL split_c0: got a=%b b=%b addr=%0d want 1 0 2", bus.rd_gnt_a, bus.rd_gnt_b, bus.rf_r_addr); end
    @(negedge clk);
    bus.wr_req_a = 1'b0; bus.rd_req_a = 1'b0;
    #1;
    tests++; if (bus.rd_gnt_b !== 1'b1) begin fails++; $display("FAIL split_c1: got b=%b want 1", bus.rd_gnt_b); end
    tests++; if (bus.rd_vld_a !== 1'b1 || bus.rd_data_a !== 32'h2A2A2A2A) begin fails++; $display("FAIL split_a_data: got vld=%b data=%h want 1 2a2a2a2a", bus.rd_vld_a, bus.rd_data_a); end
    @(negedge clk);
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd3;
    bus.rd_req_b = 1'b1; bus.rd_addr_b = 4'd9;
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b0 || bus.rd_gnt_b !== 1'b1) begin fails++; $display("FAIL split_ptr_b: got a=%b b=%b want 0 1", bus.rd_gnt_a, bus.rd_gnt_b); end
`endif
    @(negedge clk);
    idle();
    #1;
    tests++; if (bus.rd_vld_b !== 1'b1 || bus.rd_data_b !== 32'h99) begin fails++; $display("FAIL split_tail: got vld=%b data=%h want 1 99", bus.rd_vld_b, bus.rd_data_b); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd3;
    bus.rd_req_b = 1'b1; bus.rd_addr_b = 4'd9;
    bus.wr_req_a = 1'b1; bus.wr_addr_a = 4'd12; bus.wr_data_a = 32'hC0;
    bus.wr_req_b = 1'b1; bus.wr_addr_b = 4'd13; bus.wr_data_b = 32'hD0;
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b1 || bus.wr_gnt_a !== 1'b1) begin fails++; $display("FAIL mid_pre_gnt: got rd=%b wr=%b want 1 1", bus.rd_gnt_a, bus.wr_gnt_a); end
    @(negedge clk);
    idle();
    clr_n = 1'b0;
    #1;
    tests++; if (bus.rd_vld_a !== 1'b0 || bus.rd_data_a !== 32'h0) begin fails++; $display("FAIL mid_cancel: got vld=%b data=%h want 0 0", bus.rd_vld_a, bus.rd_data_a); end
    @(negedge clk);
    clr_n = 1'b1;
    bus.rd_req_a = 1'b1; bus.rd_addr_a = 4'd3;
    bus.rd_req_b = 1'b1; bus.rd_addr_b = 4'd9;
    bus.wr_req_a = 1'b1; bus.wr_addr_a = 4'd12; bus.wr_data_a = 32'hC0;
    bus.wr_req_b = 1'b1; bus.wr_addr_b = 4'd13; bus.wr_data_b = 32'hD0;
    #1;
    tests++; if (bus.rd_gnt_a !== 1'b1 || bus.rd_gnt_b !== 1'b0) begin fails++; $display("FAIL mid_rd_ptr: got a=%b b=%b want 1 0", bus.rd_gnt_a, bus.rd_gnt_b); end
    tests++; if (bus.wr_gnt_a !== 1'b1 || bus.rf_w_addr !== 4'd12) begin fails++; $display("FAIL mid_wr_ptr: got a=%b addr=%0d want 1 12", bus.wr_gnt_a, bus.rf_w_addr); end
    @(negedge clk);
    idle();
    #1;
    tests++; if (bus.rd_vld_a !== 1'b1 || bus.rd_data_a !== 32'hDEADBEEF) begin fails++; $display("FAIL mid_reissue: got vld=%b data=%h want 1 deadbeef", bus.rd_vld_a, bus.rd_data_a); end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    clr_n  = 1'b0;
    idle();
    test_reset();
    test_single_read();
    test_dual_read();
    test_dual_write();
    test_raw();
    test_raw_split();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
